tcm4671_spi: RTL and testbench
==============================

# tcm4671_spi

SPI master for a single TMC4671 motor-control IC. It converts one register-access request into one 40-bit SPI datagram: a write/read flag, a 7-bit address and 32 data bits. On reads it returns the 32-bit register value. It sits between the motor-control logic and the TMC4671's SPI pins.

## Interface
Parameters:
- `CLK_DIV`, default 2: system-clock cycles per SCK half-period, ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `transmit`  in  1  start request; its rising edge starts a datagram.
- `address`  in  7  TMC4671 register address.
- `writeNOTread`  in  1  1 = write, 0 = read.
- `data_in`  in  32  write data; ignored on reads.
- `data_out`  out  32  last received 32-bit payload.
- `SCK`  out  1  SPI clock; idles high (mode 3).
- `MOSI`  out  1  serial data to the TMC4671, MSB first.
- `MISO`  in  1  serial data from the TMC4671.
- `nSCS`  out  1  active-low chip select.
- `done`  out  1  transfer-complete flag.

## Operation
- Frame layout: 40 bits, shifted MSB first.
  - Bit 39 = `writeNOTread`.
  - Bits 38:32 = `address`.
  - Bits 31:0 = `data_in` for writes, zero for reads.
- Received frame: bits 31:0 of the 40 bits shifted in on `MISO` are the payload. Bits 39:32, the status byte, are discarded.
- Start condition: in IDLE, a clock where `transmit`=1 and its registered previous value was 0.
  - On that clock, `address`, `writeNOTread` and `data_in` are latched into the 40-bit shift register and `done` clears.
  - A level held high across several cycles starts exactly one datagram.
  - `transmit` activity while not IDLE is ignored. The edge detector still tracks the level, so a level still high at completion does not restart.
- States:
  - IDLE → SETUP on the start condition.
  - SETUP → SHIFT.
  - SHIFT → HOLD after the 40th SCK rising edge.
  - HOLD → IDLE.
- SPI mode 3:
  - `MOSI` changes only on SCK falling edges. It also changes at the start edge, when it takes bit 39.
  - `MISO` is sampled on SCK rising edges into the shift register LSB.
- Completion, at the HOLD→IDLE transition:
  - `nSCS` returns to 1.
  - `done` sets to 1 and stays 1 until the next accepted start.
  - `data_out` loads the received payload on reads only.
- Reset, including mid-frame, applies these values on the next clock:
  - `nSCS`=1, `SCK`=1, `MOSI`=0, `done`=0, `data_out`=0.
  - State returns to IDLE and the edge detector clears.

## Timing
Let D = `CLK_DIV`. Cycle 0 is the start edge.
- Cycle 0: `nSCS`=0, `MOSI`=bit 39, `SCK`=1.
- SETUP lasts D cycles, then `SCK` falls.
- SHIFT: each bit is D cycles low followed by D cycles high.
  - The falling edge for bit k>0 presents bit 39−k.
  - The rising edge samples `MISO`.
  - The SHIFT phase is 40 SCK periods, 80·D cycles in total.
- HOLD lasts D cycles after the last rising edge. `SCK` stays high.
- Completion (`nSCS`=1, `done`=1, `data_out` valid) occurs at cycle 82·D; with D=2 that is cycle 164.
- `SCK` is exactly 1 whenever `nSCS`=1.
- Earliest next start is the cycle after `done` rises, so the minimum `nSCS`-high time is one clock.
- A start edge coincident with `reset`: reset wins and no transfer starts.

## Configuration
- Macro `TCM4671_WRITE_READBACK_EN`.
- Defined: `data_out` also loads the received payload after write datagrams.
- Undefined: `data_out` is unchanged by writes and updates only after reads.

## Test plan
- Reset pulse -> `nSCS`=1, `SCK`=1, `MOSI`=0, `done`=0, `data_out`=0.
- Read, `address`=1, D=2, MISO model returns 0x00_DEADBEEF -> MOSI stream 0x01_00000000; exactly 40 SCK rising edges; `done`=1 and `data_out`=0xDEADBEEF at cycle 164.
- After `done`, write `address`=0x7F, `data_in`=0x12345678 with `transmit` held high for 2 cycles -> MOSI 0xFF_12345678; exactly one frame; `data_out` unchanged (still 0xDEADBEEF) unless the macro is defined.
- `transmit` edges pulsed mid-frame -> ignored; frame length and data are unchanged.
- `reset` asserted at bit 20 -> next clock `nSCS`=1, `SCK`=1, `done`=0, state IDLE; a following read completes normally.
- Mode-3 check with D=3 -> MOSI stable across every SCK rising edge; `SCK` high whenever `nSCS`=1; completion at cycle 246.

Source files
------------

// File: rtl/tcm4671_spi.sv
// -----------------------------------------------------------------------------
// tcm4671_spi
// SPI master (mode 3) for one TMC4671 motor-control IC. A rising edge on
// `transmit` sends one 40-bit datagram:
//   [39]    writeNOTread
//   [38:32] address
//   [31:0]  data_in for writes, zero for reads
// The same shift register collects MISO at its LSB. On completion the low 32
// received bits are the register payload.
//
// Timing, with D = CLK_DIV and cycle 0 = start edge:
//   SETUP      D cycles, SCK high
//   SHIFT      40 bits, each D cycles low then D cycles high
//   HOLD       D cycles, SCK high
//   completion at cycle 82*D
//
// Parameters:
//   CLK_DIV       system clocks per SCK half-period (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   transmit      start request; its rising edge starts a datagram
//   address       7-bit register address
//   writeNOTread  1 = write, 0 = read
//   data_in       32-bit write data
//   data_out      last received payload
//   SCK           SPI clock, idles high
//   MOSI          serial out, MSB first
//   MISO          serial in
//   nSCS          active-low chip select
//   done          transfer complete; held until the next accepted start
//
// Optional feature:
//   TCM4671_WRITE_READBACK_EN  when defined, data_out also loads the payload
//                              received during write datagrams.
// -----------------------------------------------------------------------------
module tcm4671_spi #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        transmit,
    input  logic [6:0]  address,
    input  logic        writeNOTread,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        nSCS,
    output logic        done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic [39:0]       shift_q, shift_d;
    logic              wr_q, wr_d;
    logic              trans_q, trans_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              nscs_q, nscs_d;
    logic              done_q, done_d;
    logic [31:0]       dout_q, dout_d;
    logic              start_s;
    logic              half_end_s;

    assign start_s    = (state_q == ST_IDLE) && transmit && !trans_q;
    assign half_end_s = (div_q == DIV_MAX);

    // Next-state and output logic for the datagram sequencer.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wr_d    = wr_q;
        trans_d = transmit;   // edge detector follows the level in every state
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        nscs_d  = nscs_q;
        done_d  = done_q;
        dout_d  = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    shift_d = {writeNOTread, address,
                               (writeNOTread ? data_in : 32'd0)};
                    wr_d    = writeNOTread;
                    mosi_d  = writeNOTread;   // bit 39 goes out at the start edge
                    nscs_d  = 1'b0;
                    sck_d   = 1'b1;
                    done_d  = 1'b0;
                    div_d   = {DIV_W{1'b0}};
                    state_d = ST_SETUP;
                end else begin
                    div_d   = {DIV_W{1'b0}};
                end
            end

            ST_SETUP: begin
                if (half_end_s) begin
                    // First falling edge: bit 39 is already on MOSI.
                    sck_d   = 1'b0;
                    div_d   = {DIV_W{1'b0}};
                    bit_d   = 6'd0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d   = div_q + DIV_W'(1);
                end
            end

            ST_SHIFT: begin
                if (!half_end_s) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = {DIV_W{1'b0}};
                    if (!sck_q) begin
                        // Rising edge: sample MISO, which also moves the next
                        // transmit bit into shift_q[39].
                        sck_d   = 1'b1;
                        shift_d = {shift_q[38:0], MISO};
                    end else if (bit_q == 6'd39) begin
                        // High half of the last bit finished; SCK stays high.
                        state_d = ST_HOLD;
                    end else begin
                        sck_d  = 1'b0;
                        bit_d  = bit_q + 6'd1;
                        mosi_d = shift_q[39];
                    end
                end
            end

            ST_HOLD: begin
                if (half_end_s) begin
                    state_d = ST_IDLE;
                    nscs_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
`ifdef TCM4671_WRITE_READBACK_EN
                    dout_d  = shift_q[31:0];
`else
                    if (!wr_q) begin
                        dout_d = shift_q[31:0];
                    end else begin
                        dout_d = dout_q;
                    end
`endif
                end else begin
                    div_d   = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sck_d   = 1'b1;
                nscs_d  = 1'b1;
                mosi_d  = 1'b0;
                div_d   = {DIV_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= 6'd0;
            shift_q <= 40'd0;
            wr_q    <= 1'b0;
            trans_q <= 1'b0;
            sck_q   <= 1'b1;
            mosi_q  <= 1'b0;
            nscs_q  <= 1'b1;
            done_q  <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            trans_q <= trans_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            nscs_q  <= nscs_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign nSCS     = nscs_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tcm4671_spi.sv
module tb_tcm4671_spi;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  address;
    logic        writeNOTread;
    logic [31:0] data_in;

    logic        transmit2, transmit3;
    logic [31:0] dout2, dout3;
    logic        sck2, sck3, mosi2, mosi3, nscs2, nscs3, done2, done3;
    logic        miso2, miso3;

    logic [39:0] reply2 = 40'd0, reply3 = 40'd0;
    logic [39:0] cap2 = 40'd0, cap3 = 40'd0;
    int          rise2 = 0, rise3 = 0;
    int          viol2 = 0, viol3 = 0;
    logic        psck2, pmosi2, psck3, pmosi3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tcm4671_spi #(.CLK_DIV(2)) u2 (
        .clk(clk), .reset(reset), .transmit(transmit2), .address(address),
        .writeNOTread(writeNOTread), .data_in(data_in), .data_out(dout2),
        .SCK(sck2), .MOSI(mosi2), .MISO(miso2), .nSCS(nscs2), .done(done2)
    );

    tcm4671_spi #(.CLK_DIV(3)) u3 (
        .clk(clk), .reset(reset), .transmit(transmit3), .address(address),
        .writeNOTread(writeNOTread), .data_in(data_in), .data_out(dout3),
        .SCK(sck3), .MOSI(mosi3), .MISO(miso3), .nSCS(nscs3), .done(done3)
    );

    // TMC4671 model: presents reply bit 39-k before the k-th rising SCK edge.
    assign miso2 = (rise2 < 40) ? reply2[39 - rise2] : 1'b0;
    assign miso3 = (rise3 < 40) ? reply3[39 - rise3] : 1'b0;

    always @(posedge sck2) begin
        if (nscs2 === 1'b0) begin
            cap2  = {cap2[38:0], mosi2};
            rise2 = rise2 + 1;
        end
    end

    always @(posedge sck3) begin
        if (nscs3 === 1'b0) begin
            cap3  = {cap3[38:0], mosi3};
            rise3 = rise3 + 1;
        end
    end

    // Mode-3 watchers: MOSI must not move on an SCK rise, SCK high while idle.
    always @(negedge clk) begin
        if (psck2 === 1'b0 && sck2 === 1'b1 && mosi2 !== pmosi2) viol2 = viol2 + 1;
        if (nscs2 === 1'b1 && sck2 !== 1'b1) viol2 = viol2 + 1;
        if (psck3 === 1'b0 && sck3 === 1'b1 && mosi3 !== pmosi3) viol3 = viol3 + 1;
        if (nscs3 === 1'b1 && sck3 !== 1'b1) viol3 = viol3 + 1;
        psck2 = sck2; pmosi2 = mosi2; psck3 = sck3; pmosi3 = mosi3;
    end

    // Called #1 after a posedge; returns #1 after the start edge (cycle 0).
    task automatic kick2(input logic [6:0] a, input logic w, input logic [31:0] d,
                         input logic [39:0] r);
        address = a; writeNOTread = w; data_in = d; reply2 = r;
        rise2 = 0; cap2 = 40'd0; transmit2 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic kick3(input logic [6:0] a, input logic w, input logic [31:0] d,
                         input logic [39:0] r);
        address = a; writeNOTread = w; data_in = d; reply3 = r;
        rise3 = 0; cap3 = 40'd0; transmit3 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; transmit2 = 1'b0; transmit3 = 1'b0;
        address = 7'd0; writeNOTread = 1'b0; data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (nscs2 !== 1'b1) begin n_fail++; $display("FAIL reset_nscs actual=%b required=1", nscs2); end
        n_checks++; if (sck2 !== 1'b1) begin n_fail++; $display("FAIL reset_sck actual=%b required=1", sck2); end
        n_checks++; if (mosi2 !== 1'b0) begin n_fail++; $display("FAIL reset_mosi actual=%b required=0", mosi2); end
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b required=0", done2); end
        n_checks++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL reset_dout actual=%h required=0", dout2); end
        n_checks++; if ({nscs3, sck3, mosi3, done3} !== 4'b1100) begin n_fail++; $display("FAIL reset_u3 actual=%b required=1100", {nscs3, sck3, mosi3, done3}); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read;
        kick2(7'h01, 1'b0, 32'hFFFF_FFFF, 40'h00_DEAD_BEEF);
        transmit2 = 1'b0;
        n_checks++; if ({nscs2, sck2, mosi2} !== 3'b010) begin n_fail++; $display("FAIL read_cycle0 actual=%b required=010", {nscs2, sck2, mosi2}); end
        repeat (163) @(posedge clk);
        #1;
        n_checks++; if ({nscs2, done2} !== 2'b00) begin n_fail++; $display("FAIL read_c163 actual=%b required=00", {nscs2, done2}); end
        @(posedge clk); #1;
        n_checks++; if ({nscs2, done2, sck2} !== 3'b111) begin n_fail++; $display("FAIL read_c164 actual=%b required=111", {nscs2, done2, sck2}); end
        n_checks++; if (dout2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_dout actual=%h required=deadbeef", dout2); end
        n_checks++; if (cap2 !== 40'h01_0000_0000) begin n_fail++; $display("FAIL read_mosi actual=%h required=0100000000", cap2); end
        n_checks++; if (rise2 !== 40) begin n_fail++; $display("FAIL read_edges actual=%0d required=40", rise2); end
    endtask

    // Starts on the cycle right after done rose.
    task automatic test_back_to_back;
        logic [31:0] exp_dout;
`ifdef TCM4671_WRITE_READBACK_EN
        exp_dout = 32'hCAFE_F00D;
`else
        exp_dout = 32'hDEAD_BEEF;
`endif
        kick2(7'h7F, 1'b1, 32'h1234_5678, 40'hAA_CAFE_F00D);
        n_checks++; if ({nscs2, mosi2, done2} !== 3'b010) begin n_fail++; $display("FAIL b2b_start actual=%b required=010", {nscs2, mosi2, done2}); end
        @(posedge clk); #1;
        transmit2 = 1'b0;
        repeat (162) @(posedge clk);
        #1;
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL b2b_c163 actual=%b required=0", done2); end
        @(posedge clk); #1;
        n_checks++; if ({nscs2, done2} !== 2'b11) begin n_fail++; $display("FAIL b2b_c164 actual=%b required=11", {nscs2, done2}); end
        n_checks++; if (cap2 !== 40'hFF_1234_5678) begin n_fail++; $display("FAIL b2b_mosi actual=%h required=ff12345678", cap2); end
        n_checks++; if (dout2 !== exp_dout) begin n_fail++; $display("FAIL b2b_dout actual=%h required=%h", dout2, exp_dout); end
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if ({nscs2, done2, rise2} !== {2'b11, 32'd40}) begin n_fail++; $display("FAIL b2b_single nscs=%b done=%b edges=%0d required 1 1 40", nscs2, done2, rise2); end
    endtask

    task automatic test_midframe_ignore;
        kick2(7'h05, 1'b0, 32'd0, 40'h00_0BAD_F00D);
        transmit2 = 1'b0;
        for (int c = 1; c <= 163; c++) begin
            @(posedge clk); #1;
            if (c == 30 || c == 80 || c == 150) transmit2 = 1'b1;
            else if (c == 31 || c == 81) transmit2 = 1'b0;
        end
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL mid_c163 actual=%b required=0", done2); end
        @(posedge clk); #1;
        n_checks++; if ({nscs2, done2} !== 2'b11) begin n_fail++; $display("FAIL mid_c164 actual=%b required=11", {nscs2, done2}); end
        n_checks++; if (dout2 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mid_dout actual=%h required=0badf00d", dout2); end
        n_checks++; if (cap2 !== 40'h05_0000_0000) begin n_fail++; $display("FAIL mid_mosi actual=%h required=0500000000", cap2); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if ({nscs2, rise2} !== {1'b1, 32'd40}) begin n_fail++; $display("FAIL mid_norestart nscs=%b edges=%0d required 1 40", nscs2, rise2); end
        transmit2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe;
        kick2(7'h10, 1'b0, 32'd0, 40'h00_FFFF_FFFF);
        transmit2 = 1'b0;
        repeat (85) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({nscs2, sck2, mosi2, done2} !== 4'b1100) begin n_fail++; $display("FAIL rstmid_out actual=%b required=1100", {nscs2, sck2, mosi2, done2}); end
        n_checks++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL rstmid_dout actual=%h required=0", dout2); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (nscs2 !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle actual=%b required=1", nscs2); end
        kick2(7'h22, 1'b0, 32'd0, 40'h00_1357_9BDF);
        transmit2 = 1'b0;
        repeat (164) @(posedge clk);
        #1;
        n_checks++; if ({nscs2, done2} !== 2'b11) begin n_fail++; $display("FAIL rstmid_next_done actual=%b required=11", {nscs2, done2}); end
        n_checks++; if (dout2 !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rstmid_next_dout actual=%h required=13579bdf", dout2); end
    endtask

    task automatic test_reset_coincident;
        address = 7'h03; writeNOTread = 1'b0; data_in = 32'd0;
        reset = 1'b1; transmit2 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({nscs2, done2} !== 2'b10) begin n_fail++; $display("FAIL coinc_edge actual=%b required=10", {nscs2, done2}); end
        reset = 1'b0; transmit2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if ({nscs2, sck2} !== 2'b11) begin n_fail++; $display("FAIL coinc_nostart actual=%b required=11", {nscs2, sck2}); end
    endtask

    task automatic test_mode3_div3;
        kick3(7'h2A, 1'b0, 32'd0, 40'h00_A5A5_A5A5);
        transmit3 = 1'b0;
        repeat (245) @(posedge clk);
        #1;
        n_checks++; if ({nscs3, done3} !== 2'b00) begin n_fail++; $display("FAIL d3_c245 actual=%b required=00", {nscs3, done3}); end
        @(posedge clk); #1;
        n_checks++; if ({nscs3, done3} !== 2'b11) begin n_fail++; $display("FAIL d3_c246 actual=%b required=11", {nscs3, done3}); end
        n_checks++; if (dout3 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL d3_dout actual=%h required=a5a5a5a5", dout3); end
        n_checks++; if (cap3 !== 40'h2A_0000_0000) begin n_fail++; $display("FAIL d3_mosi actual=%h required=2a00000000", cap3); end
        n_checks++; if (rise3 !== 40) begin n_fail++; $display("FAIL d3_edges actual=%0d required=40", rise3); end
        n_checks++; if (viol3 !== 0) begin n_fail++; $display("FAIL d3_mode3 violations actual=%0d required=0", viol3); end
        n_checks++; if (viol2 !== 0) begin n_fail++; $display("FAIL d2_mode3 violations actual=%0d required=0", viol2); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_back_to_back;
        test_midframe_ignore;
        test_reset_midframe;
        test_reset_coincident;
        test_mode3_div3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
